// File: rtl/cache_pkg.sv
// cache_pkg: shared parameters, controller state encoding and address-field
// helpers for the 2-way set-associative cache controller.
//   ADDR_W   byte address width
//   OFFSET_W byte offset within a 128-bit block
//   INDEX_W  set index width
//   TAG_W    tag width (what is left of the address)
//   NUM_SETS number of sets
package cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = 2;
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int NUM_SETS = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } ctrl_state_t;

    // Field order matches the address layout: tag in the MSBs, offset in the LSBs.
    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

    // Block-aligned memory address for a given tag and set.
    function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0]   tag,
                                                      input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_meta_store.sv
// cache_meta_store: tag / valid / dirty / LRU state for a 2-way cache.
//   index, tag        set and tag being looked up (the latched request)
//   hit, hit_way      combinational lookup result
//   victim            replacement way: first invalid way (way 0 first), else LRU
//   victim_dirty      victim holds a valid dirty line that needs write-back
//   victim_tag        tag of the victim line (used for the write-back address)
//   touch_*           access on a hit: LRU points at the other way, write sets dirty
//   clean_*           clear dirty after write-back completes
//   fill_*            install the request tag into a way as valid and clean
module cache_meta_store
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    output logic               hit_way,
    output logic               victim,
    output logic               victim_dirty,
    output logic [TAG_W-1:0]   victim_tag,
    input  logic               touch_en,
    input  logic               touch_way,
    input  logic               touch_write,
    input  logic               clean_en,
    input  logic               clean_way,
    input  logic               fill_en,
    input  logic               fill_way
);

    logic [TAG_W-1:0]    tag_q   [NUM_SETS][2];
    logic [1:0]          valid_q [NUM_SETS];
    logic [1:0]          dirty_q [NUM_SETS];
    logic [NUM_SETS-1:0] lru_q;

    logic hit0;
    logic hit1;

    always_comb begin
        hit0 = valid_q[index][0] && (tag_q[index][0] == tag);
        hit1 = valid_q[index][1] && (tag_q[index][1] == tag);
        hit     = hit0 || hit1;
        hit_way = hit1;
        if (!valid_q[index][0]) begin
            victim = 1'b0;
        end else if (!valid_q[index][1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[index];
        end
        victim_dirty = valid_q[index][victim] && dirty_q[index][victim];
        victim_tag   = tag_q[index][victim];
    end

    // NOTE: these arrays are small flop banks, not RAM macros, so clearing them
    // on the asynchronous reset is cheap and makes every line invalid at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < 2; w++) begin
                    tag_q[s][w] <= '0;
                end
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            lru_q <= '0;
        end else begin
            // The controller never raises more than one of these per cycle.
            if (touch_en) begin
                lru_q[index] <= ~touch_way;
                if (touch_write) begin
                    dirty_q[index][touch_way] <= 1'b1;
                end
            end
            if (clean_en) begin
                dirty_q[index][clean_way] <= 1'b0;
            end
            if (fill_en) begin
                tag_q[index][fill_way]   <= tag;
                valid_q[index][fill_way] <= 1'b1;
                dirty_q[index][fill_way] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: sequencing controller for a 2-way set-associative,
// write-back, LRU cache. Moves no data; it drives the data-array enables and
// block-level memory requests and owns all metadata (via cache_meta_store).
//   cpu_req_*      one request at a time, accepted when cpu_req_ready is high
//   cpu_resp_*     one-cycle completion pulse; hit reports the original lookup
//   arr_*          data-array way/set/offset select and read/write enables
//   mem_req_*      block write-back (write=1) or block fetch (write=0)
//   mem_resp_valid fetch data valid or write-back acknowledge
module cache_ctrl_2way
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req_valid,
    input  logic                cpu_req_write,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    output logic                cpu_req_ready,
    output logic                cpu_resp_valid,
    output logic                cpu_resp_hit,
    output logic                arr_way,
    output logic [INDEX_W-1:0]  arr_index,
    output logic [OFFSET_W-1:0] arr_offset,
    output logic                arr_rd_en,
    output logic                arr_wr_byte_en,
    output logic                arr_wr_block_en,
    output logic                mem_req_valid,
    output logic                mem_req_write,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    // started_q keeps cpu_req_ready low until the first edge after reset.
    logic              started_q;
    logic              req_write_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              miss_flag_q;
    logic              victim_q;
    logic [TAG_W-1:0]  victim_tag_q;
    addr_fields_t      req_f;

    logic             hit;
    logic             hit_way;
    logic             victim;
    logic             victim_dirty;
    logic [TAG_W-1:0] victim_tag;
    logic             touch_en;
    logic             clean_en;
    logic             fill_en;

    assign req_f      = split_addr(req_addr_q);
    assign arr_index  = req_f.index;
    assign arr_offset = req_f.offset;

    cache_meta_store u_meta (
        .clk          (clk),
        .rst_n        (rst_n),
        .index        (req_f.index),
        .tag          (req_f.tag),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim       (victim),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .touch_en     (touch_en),
        .touch_way    (hit_way),
        .touch_write  (req_write_q),
        .clean_en     (clean_en),
        .clean_way    (victim_q),
        .fill_en      (fill_en),
        .fill_way     (victim_q)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request, miss and victim bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q    <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            miss_flag_q  <= 1'b0;
            victim_q     <= 1'b0;
            victim_tag_q <= '0;
        end else begin
            started_q <= 1'b1;
            if (cpu_req_valid && cpu_req_ready) begin
                req_write_q <= cpu_req_write;
                req_addr_q  <= cpu_req_addr;
                miss_flag_q <= 1'b0;
            end
            // The victim is captured on the first lookup; the re-lookup after a
            // fill always hits, so it never overwrites it.
            if (state_q == LOOKUP && !hit) begin
                miss_flag_q  <= 1'b1;
                victim_q     <= victim;
                victim_tag_q <= victim_tag;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (cpu_req_valid && cpu_req_ready) state_d = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    state_d = RESP;
                end else if (victim_dirty) begin
                    state_d = WB_REQ;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            WB_REQ:    if (mem_req_ready)  state_d = WB_WAIT;
            WB_WAIT:   if (mem_resp_valid) state_d = FILL_REQ;
            FILL_REQ:  if (mem_req_ready)  state_d = FILL_WAIT;
            FILL_WAIT: if (mem_resp_valid) state_d = LOOKUP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic.
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cpu_req_ready   = 1'b0;
        cpu_resp_valid  = 1'b0;
        cpu_resp_hit    = 1'b0;
        arr_way         = 1'b0;
        arr_rd_en       = 1'b0;
        arr_wr_byte_en  = 1'b0;
        arr_wr_block_en = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = '0;
        touch_en        = 1'b0;
        clean_en        = 1'b0;
        fill_en         = 1'b0;
        case (state_q)
            IDLE: cpu_req_ready = started_q;
            LOOKUP: begin
                if (hit) begin
                    arr_way        = hit_way;
                    arr_rd_en      = !req_write_q;
                    arr_wr_byte_en = req_write_q;
                    touch_en       = 1'b1;
                end
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = block_addr(victim_tag_q, req_f.index);
                arr_rd_en     = 1'b1;
                arr_way       = victim_q;
            end
            WB_WAIT: clean_en = mem_resp_valid;
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = block_addr(req_f.tag, req_f.index);
            end
            FILL_WAIT: begin
                arr_way         = victim_q;
                arr_wr_block_en = mem_resp_valid;
                fill_en         = mem_resp_valid;
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_hit   = !miss_flag_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb_cache_ctrl_2way: scoreboard bench for cache_ctrl_2way. A reference cache
// model predicts memory transactions, array accesses and response hit bits when
// each request is issued; monitors pop and compare them as the DUT produces them.
module tb_cache_ctrl_2way;
    import cache_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cpu_req_valid;
    logic                cpu_req_write;
    logic [ADDR_W-1:0]   cpu_req_addr;
    logic                cpu_req_ready;
    logic                cpu_resp_valid;
    logic                cpu_resp_hit;
    logic                arr_way;
    logic [INDEX_W-1:0]  arr_index;
    logic [OFFSET_W-1:0] arr_offset;
    logic                arr_rd_en;
    logic                arr_wr_byte_en;
    logic                arr_wr_block_en;
    logic                mem_req_valid;
    logic                mem_req_write;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_req_ready;
    logic                mem_resp_valid;

    always #5 clk = ~clk;

    cache_ctrl_2way u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_write   (cpu_req_write),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_ready   (cpu_req_ready),
        .cpu_resp_valid  (cpu_resp_valid),
        .cpu_resp_hit    (cpu_resp_hit),
        .arr_way         (arr_way),
        .arr_index       (arr_index),
        .arr_offset      (arr_offset),
        .arr_rd_en       (arr_rd_en),
        .arr_wr_byte_en  (arr_wr_byte_en),
        .arr_wr_block_en (arr_wr_block_en),
        .mem_req_valid   (mem_req_valid),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_resp_valid  (mem_resp_valid)
    );

    // kind: 1 = byte read, 2 = byte write, 3 = block refill write
    typedef struct packed {
        logic [1:0]          kind;
        logic                way;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } arr_ev_t;

    typedef struct packed {
        logic              write;
        logic              way;
        logic [ADDR_W-1:0] addr;
    } mem_ev_t;

    arr_ev_t exp_arr_q[$];
    mem_ev_t exp_mem_q[$];
    logic    exp_resp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder knobs.
    int stall_cycles = 0;
    int resp_lat     = 2;
    bit early_resp   = 1'b0;

    // Reference cache model.
    logic [TAG_W-1:0] m_tag   [NUM_SETS][2];
    logic             m_valid [NUM_SETS][2];
    logic             m_dirty [NUM_SETS][2];
    logic             m_lru   [NUM_SETS];

    task automatic model_clear();
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w]   = '0;
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            m_lru[s] = 1'b0;
        end
    endtask

    task automatic model_access(input logic w, input logic [ADDR_W-1:0] a, output logic hit);
        logic [TAG_W-1:0]    tg;
        logic [INDEX_W-1:0]  ix;
        logic [OFFSET_W-1:0] of;
        logic                way;
        tg  = a[9:6];
        ix  = a[5:4];
        of  = a[3:0];
        hit = 1'b1;
        if (m_valid[ix][0] && m_tag[ix][0] == tg) begin
            way = 1'b0;
        end else if (m_valid[ix][1] && m_tag[ix][1] == tg) begin
            way = 1'b1;
        end else begin
            hit = 1'b0;
            if (!m_valid[ix][0])      way = 1'b0;
            else if (!m_valid[ix][1]) way = 1'b1;
            else                      way = m_lru[ix];
            if (m_valid[ix][way] && m_dirty[ix][way]) begin
                exp_mem_q.push_back('{1'b1, way, {m_tag[ix][way], ix, 4'h0}});
            end
            exp_mem_q.push_back('{1'b0, way, {tg, ix, 4'h0}});
            exp_arr_q.push_back('{2'd3, way, ix, of});
            m_tag[ix][way]   = tg;
            m_valid[ix][way] = 1'b1;
            m_dirty[ix][way] = 1'b0;
        end
        exp_arr_q.push_back('{(w ? 2'd2 : 2'd1), way, ix, of});
        m_lru[ix] = ~way;
        if (w) m_dirty[ix][way] = 1'b1;
        exp_resp_q.push_back(hit);
    endtask

    // Issue one request; optionally wait for its response and, on a predicted
    // hit, require the response two cycles after the accept cycle.
    task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input bit wait_resp);
        logic eh;
        int   n;
        model_access(w, a, eh);
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_write = w;
        cpu_req_addr  = a;
        n = 0;
        while (!cpu_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            cpu_req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cpu_req_valid = 1'b0;
        if (!wait_resp) return;
        n = 1;
        while (!cpu_resp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_resp_valid) check("resp_timeout", 32'd0, 32'd1);
        else if (eh)         check("hit_latency", n, 32'd2);
        @(negedge clk);
    endtask

    // Memory responder: optional stall, handshake check, then response.
    initial begin : mem_model
        logic              hw;
        logic [ADDR_W-1:0] ha;
        bit                ab;
        mem_ev_t           e;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid) begin
                hw = mem_req_write;
                ha = mem_req_addr;
                ab = 1'b0;
                for (int i = 0; i < stall_cycles && !ab; i++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    else check("req_stable", {mem_req_valid, mem_req_write, mem_req_addr},
                               {1'b1, hw, ha});
                end
                if (!ab) begin
                    if (exp_mem_q.size() == 0) begin
                        check("mem_unexpected", {mem_req_write, mem_req_addr}, 32'h7ff);
                    end else begin
                        e = exp_mem_q.pop_front();
                        check("mem_write", mem_req_write, e.write);
                        check("mem_addr", mem_req_addr, e.addr);
                        if (e.write) check("wb_arr_read", {arr_rd_en, arr_way}, {1'b1, e.way});
                    end
                    mem_req_ready = 1'b1;
                    if (early_resp) mem_resp_valid = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                    if (!early_resp) begin
                        for (int i = 0; i < resp_lat && !ab; i++) begin
                            @(negedge clk);
                            if (!rst_n) ab = 1'b1;
                        end
                        if (!ab) mem_resp_valid = 1'b1;
                    end
                    if (!ab) @(negedge clk);
                    mem_resp_valid = 1'b0;
                end
            end
        end
    end

    // Output monitor: response hit bits and array accesses.
    initial begin : out_monitor
        arr_ev_t got;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (cpu_resp_valid) begin
                    if (exp_resp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
                    else check("resp_hit", cpu_resp_hit, exp_resp_q.pop_front());
                end
                if (arr_wr_byte_en || arr_wr_block_en || (arr_rd_en && !mem_req_valid)) begin
                    check("arr_en_excl", $countones({arr_rd_en, arr_wr_byte_en, arr_wr_block_en}), 32'd1);
                    got.kind   = arr_wr_block_en ? 2'd3 : (arr_wr_byte_en ? 2'd2 : 2'd1);
                    got.way    = arr_way;
                    got.index  = arr_index;
                    got.offset = arr_offset;
                    if (exp_arr_q.size() == 0) check("arr_unexpected", got, 32'h1ff);
                    else check("arr_access", got, exp_arr_q.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] all_outputs();
        return {7'd0, cpu_req_ready, cpu_resp_valid, cpu_resp_hit, arr_way, arr_index,
                arr_offset, arr_rd_en, arr_wr_byte_en, arr_wr_block_en, mem_req_valid,
                mem_req_write, mem_req_addr};
    endfunction

    initial begin : main
        int n;
        rst_n         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_write = 1'b0;
        cpu_req_addr  = '0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", cpu_req_ready, 32'd0);
        @(posedge clk);
        #1;
        check("ready_first_edge", cpu_req_ready, 32'd1);

        // Cold read miss into way 0, then a write hit that dirties it.
        do_req(1'b0, 10'h000, 1'b1);
        check("way0_valid", u_dut.u_meta.valid_q[0][0], 32'd1);
        do_req(1'b1, 10'h000, 1'b1);
        check("way0_dirty", u_dut.u_meta.dirty_q[0][0], 32'd1);

        // Second tag in set 0 fills the invalid way 1.
        do_req(1'b0, 10'h000, 1'b1);
        do_req(1'b0, 10'h200, 1'b1);
        check("lru_after_fill", u_dut.u_meta.lru_q[0], 32'd0);

        // Touch way 0 so the clean way 1 is replaced.
        do_req(1'b0, 10'h000, 1'b1);
        check("lru_after_hit", u_dut.u_meta.lru_q[0], 32'd1);
        do_req(1'b0, 10'h300, 1'b1);

        // Dirty victim: write-back then refill, with ready and response raised
        // together in the request cycle.
        early_resp = 1'b1;
        do_req(1'b0, 10'h200, 1'b1);
        early_resp = 1'b0;

        // A stray memory response while idle must not disturb anything.
        @(negedge clk);
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        do_req(1'b1, 10'h20f, 1'b1);

        // Memory stall during FILL_REQ.
        stall_cycles = 5;
        do_req(1'b0, 10'h1a5, 1'b1);
        stall_cycles = 0;

        // Mixed traffic over a small tag range to force replacements.
        for (int i = 0; i < 24; i++) begin
            resp_lat     = $urandom_range(0, 3);
            early_resp   = ($urandom_range(0, 3) == 0);
            stall_cycles = $urandom_range(0, 2);
            do_req(1'($urandom_range(0, 1)),
                   {4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))},
                   1'b1);
        end
        early_resp   = 1'b0;
        stall_cycles = 0;

        check("sb_mem_empty", exp_mem_q.size(), 32'd0);
        check("sb_arr_empty", exp_arr_q.size(), 32'd0);
        check("sb_resp_empty", exp_resp_q.size(), 32'd0);

        // Reset in the middle of FILL_WAIT (tag F is never used above).
        resp_lat = 40;
        do_req(1'b0, 10'h3f0, 1'b0);
        n = 0;
        while (u_dut.state_q != FILL_WAIT && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_fill_wait", (u_dut.state_q == FILL_WAIT), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", all_outputs(), 32'd0);
        check("abort_state", u_dut.state_q, IDLE);
        for (int s = 0; s < NUM_SETS; s++) begin
            check("meta_cleared", {u_dut.u_meta.valid_q[s], u_dut.u_meta.dirty_q[s],
                                   u_dut.u_meta.lru_q[s]}, 32'd0);
        end
        exp_arr_q.delete();
        exp_mem_q.delete();
        exp_resp_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        resp_lat = 1;
        // Previously cached line must miss again after the reset.
        do_req(1'b0, 10'h000, 1'b1);
        check("sb_final_empty", exp_resp_q.size() + exp_arr_q.size() + exp_mem_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
